// File: rtl/dram_rd_dma.sv
// dram_rd_dma: AXI read master that copies a contiguous block of DRAM words into a local buffer.
// Latency: AR is presented the cycle after start; each R beat is written to the buffer in the same cycle.
// Backpressure: AR fields are held until arready_i; rready_o stays high in R; one burst is outstanding at a time.
module dram_rd_dma #(
  parameter int         MAX_BEATS = 16,
  parameter int         BUF_AW    = 10,
  parameter logic [3:0] AXI_ID    = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [31:0]       src_addr_i,
  input  logic [15:0]       word_cnt_i,
  input  logic [BUF_AW-1:0] dst_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [3:0]        arid_o,
  output logic [31:0]       araddr_o,
  output logic [3:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [3:0]        rid_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic              buf_wen_o,
  output logic [BUF_AW-1:0] buf_addr_o,
  output logic [31:0]       buf_wdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  localparam logic [16:0] CAP = 17'(MAX_BEATS);

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       cur_addr;
  logic [15:0]       remaining;
  logic [BUF_AW-1:0] buf_ptr;
  logic [4:0]        beats_q;
  logic [4:0]        beat_cnt;
  logic              err;

  logic [16:0]       rem_w;
  logic [16:0]       row_w;
  logic [16:0]       mid_w;
  logic [4:0]        beats;
  logic [15:0]       rem_after;
  logic              ar_hs;
  logic              r_hs;
  logic              beat_err;

  assign arid_o    = AXI_ID;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;
  assign err_o     = err;
  assign ar_hs     = (state == S_AR) && arready_i;
  assign r_hs      = (state == S_R) && rvalid_i;
  assign rem_after = remaining - {11'd0, beats_q};

  // Burst size: smallest of words left, burst cap and words left in the current 4 KB row.
  always_comb begin
    rem_w = {1'b0, remaining};
    row_w = 17'd1024 - {7'd0, cur_addr[11:2]};
    mid_w = (rem_w < row_w) ? rem_w : row_w;
    beats = (mid_w < CAP) ? mid_w[4:0] : CAP[4:0];
  end

  // Protocol checks on the beat being accepted; any hit makes the transfer's error flag stick.
  always_comb begin
    beat_err = 1'b0;
    if (rresp_i != 2'b00)                              beat_err = 1'b1;
    if (rid_i != AXI_ID)                               beat_err = 1'b1;
    if (beat_cnt >= beats_q)                           beat_err = 1'b1;
    if (rlast_i && ((beat_cnt + 5'd1) != beats_q))     beat_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt   = state;
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
    arvalid_o   = 1'b0;
    araddr_o    = 32'd0;
    arlen_o     = 4'd0;
    rready_o    = 1'b0;
    buf_wen_o   = r_hs;
    buf_addr_o  = r_hs ? buf_ptr : '0;
    buf_wdata_o = r_hs ? rdata_i : 32'd0;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = (word_cnt_i == 16'd0) ? S_DONE : S_AR;
      end
      S_AR: begin
        arvalid_o = 1'b1;
        araddr_o  = cur_addr;
        arlen_o   = beats[3:0] - 4'd1;
        if (arready_i) state_nxt = S_R;
      end
      S_R: begin
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) state_nxt = (rem_after == 16'd0) ? S_DONE : S_AR;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: address, words left, buffer pointer, beat counting and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_addr  <= 32'd0;
      remaining <= 16'd0;
      buf_ptr   <= '0;
      beats_q   <= 5'd0;
      beat_cnt  <= 5'd0;
      err       <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start_i) begin
        cur_addr  <= src_addr_i & ~32'h3;
        remaining <= word_cnt_i;
        buf_ptr   <= dst_addr_i;
        beat_cnt  <= 5'd0;
        err       <= 1'b0;
      end
      if (ar_hs) begin
        beats_q  <= beats;
        beat_cnt <= 5'd0;
      end
      if (r_hs) begin
        buf_ptr <= buf_ptr + 1'b1;
        // Saturate so a runaway slave cannot wrap the counter back into range.
        if (beat_cnt != 5'd31) beat_cnt <= beat_cnt + 5'd1;
        if (beat_err) err <= 1'b1;
        if (rlast_i) begin
          remaining <= rem_after;
          cur_addr  <= cur_addr + {25'd0, beats_q, 2'b00};
          beat_cnt  <= 5'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_rd_dma.sv
// tb_dram_rd_dma: drives dram_rd_dma as an AXI read slave and checks it against a burst/word model.
// The model splits each request into row-bounded bursts with plain byte arithmetic.
// A single compare process checks AR and buffer-write outputs every cycle.
module tb_dram_rd_dma;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [15:0] word_cnt_i;
  logic [9:0]  dst_addr_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [3:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;
  logic        buf_wen_o;
  logic [9:0]  buf_addr_o;
  logic [31:0] buf_wdata_o;

  int tests = 0;
  int fails = 0;

  // Model state: expected AR stream (compare side), burst plan (slave side), expected buffer writes.
  logic [31:0] q_ar_addr[$];
  int          q_ar_len[$];
  logic [31:0] bur_addr[$];
  int          bur_beats[$];
  int          q_w_addr[$];
  logic [31:0] q_w_dat[$];

  dram_rd_dma dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
    .word_cnt_i(word_cnt_i), .dst_addr_i(dst_addr_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .arid_o(arid_o), .araddr_o(araddr_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .rid_i(rid_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .buf_wen_o(buf_wen_o),
    .buf_addr_o(buf_addr_o), .buf_wdata_o(buf_wdata_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] got);
    tests++;
    fails++;
    $display("FAIL %s: observed 0x%0h where nothing was expected", nm, got);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic clear_model();
    q_ar_addr.delete(); q_ar_len.delete();
    bur_addr.delete();  bur_beats.delete();
    q_w_addr.delete();  q_w_dat.delete();
  endtask

  // Split a request into bursts: at most 16 words, never past the end of a 4096-byte row.
  task automatic build_model(input logic [31:0] src, input int cnt);
    logic [31:0] a;
    int rem, rw, b;
    a   = src & 32'hFFFF_FFFC;
    rem = cnt;
    while (rem > 0) begin
      rw = (4096 - int'(a & 32'h0000_0FFF)) / 4;
      b  = rem;
      if (b > 16) b = 16;
      if (b > rw) b = rw;
      q_ar_addr.push_back(a);
      q_ar_len.push_back(b - 1);
      bur_addr.push_back(a);
      bur_beats.push_back(b);
      a   = a + 32'(4 * b);
      rem = rem - b;
    end
  endtask

  // Compare process: every cycle, check AR fields and buffer writes against the model queues.
  always @(negedge clk) begin
    int          wa;
    logic [31:0] wd;
    #2;
    if (rst) begin
      if (!rvalid_i) chk("no_wr_without_rvalid", buf_wen_o, 0);
      if (buf_wen_o) begin
        if (q_w_addr.size() == 0) fail_now("wr_unexpected", buf_addr_o);
        else begin
          wa = q_w_addr.pop_front();
          wd = q_w_dat.pop_front();
          chk("wr_addr", buf_addr_o, wa);
          chk("wr_data", buf_wdata_o, wd);
        end
      end else begin
        chk("wr_idle_addr", buf_addr_o, 0);
        chk("wr_idle_data", buf_wdata_o, 0);
      end
      if (arvalid_o) begin
        chk("arid", arid_o, 0);
        chk("arsize", arsize_o, 3'b010);
        chk("arburst", arburst_o, 2'b01);
        if (q_ar_addr.size() == 0) fail_now("ar_unexpected", araddr_o);
        else begin
          chk("araddr", araddr_o, q_ar_addr[0]);
          chk("arlen", arlen_o, q_ar_len[0]);
          if (arready_i) begin
            void'(q_ar_addr.pop_front());
            void'(q_ar_len.pop_front());
          end
        end
      end
      if (done_o) chk("busy_during_done", busy_o, 1);
    end
  end

  task automatic check_reset_outputs();
    chk("rst_busy", busy_o, 0);       chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);         chk("rst_arvalid", arvalid_o, 0);
    chk("rst_rready", rready_o, 0);   chk("rst_wen", buf_wen_o, 0);
    chk("rst_baddr", buf_addr_o, 0);  chk("rst_wdata", buf_wdata_o, 0);
    chk("rst_araddr", araddr_o, 0);   chk("rst_arlen", arlen_o, 0);
    chk("rst_arid", arid_o, 0);
  endtask

  // One transfer with the bench acting as the AXI slave.
  // Fault knobs use the global beat index (bad_resp/bad_id) or burst index (short_b/long_b); -1 disables.
  task automatic run_xfer(input logic [31:0] src, input int cnt, input int dst,
                          input int ar_stall, input int gap_pct,
                          input int bad_resp, input int bad_id,
                          input int short_b, input int long_b,
                          input int busy_cyc, input int abort_at);
    int nb, b, k, nsend, pres, acc, ar_wait, last_hs, cyc, cyc_done;
    bit presenting, in_r, fin, aborted, exp_err;
    logic [31:0] beat_addr;
    clear_model();
    build_model(src, cnt);
    nb      = bur_beats.size();
    exp_err = (bad_resp >= 0) || (bad_id >= 0) || (short_b >= 0) || (long_b >= 0);
    b = 0; k = 0; nsend = 0; pres = 0; acc = 0; ar_wait = ar_stall;
    last_hs = -1; cyc_done = -1;
    presenting = 0; in_r = 0; fin = 0; aborted = 0;
    @(negedge clk);
    start_i = 1'b1; src_addr_i = src; word_cnt_i = 16'(cnt); dst_addr_i = 10'(dst);
    arready_i = 1'b0; rvalid_i = 1'b0;
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      start_i    = (cyc == busy_cyc);
      src_addr_i = $urandom;
      word_cnt_i = 16'($urandom_range(60, 1));
      dst_addr_i = 10'($urandom);
      if (abort_at > 0 && acc == abort_at) begin
        aborted = 1;
        break;
      end
      arready_i = (ar_wait == 0);
      if (in_r && !presenting && ($urandom_range(99) >= gap_pct)) begin
        beat_addr = bur_addr[b] + 32'(4 * k);
        rdata_i   = mem(beat_addr);
        rresp_i   = (pres == bad_resp) ? 2'b10 : 2'b00;
        rid_i     = (pres == bad_id) ? 4'h3 : 4'h0;
        rlast_i   = (k == nsend - 1);
        q_w_addr.push_back((dst + pres) & 1023);
        q_w_dat.push_back(rdata_i);
        pres++;
        presenting = 1;
      end
      rvalid_i = presenting;
      #1;
      if (cyc == 0) begin
        chk("err_clear_on_start", err_o, 0);
        chk("busy_after_start", busy_o, 1);
        if (cnt == 0) chk("zero_len_done_next", done_o, 1);
        else          chk("ar_cycle_after_start", arvalid_o, 1);
      end
      if (done_o) begin
        fin = 1;
        cyc_done = cyc;
      end
      if (arvalid_o && arready_i) begin
        ar_wait = ar_stall;
        if (b < nb) begin
          in_r  = 1;
          k     = 0;
          nsend = bur_beats[b] - int'(b == short_b) + int'(b == long_b);
        end
      end else if (arvalid_o && ar_wait > 0) begin
        ar_wait--;
      end
      if (rvalid_i && rready_o) begin
        presenting = 0;
        acc++;
        if (rlast_i) begin
          in_r = 0;
          b++;
          last_hs = cyc;
        end else k++;
      end
    end
    start_i = 1'b0;
    if (aborted) begin
      rst = 1'b0; rvalid_i = 1'b0; arready_i = 1'b0;
      @(negedge clk); #1;
      check_reset_outputs();
      clear_model();
      rst = 1'b1;
      @(negedge clk); #1;
      chk("no_done_after_reset", done_o, 0);
      chk("idle_after_reset", busy_o, 0);
    end else if (!fin) begin
      fail_now("timeout_waiting_done", busy_o);
      rst = 1'b0; rvalid_i = 1'b0;
      repeat (2) @(negedge clk);
      clear_model();
      rst = 1'b1;
    end else begin
      chk("done_err", err_o, exp_err);
      if (cnt != 0) chk("done_after_last_rlast", cyc_done - last_hs, 1);
      chk("bursts_completed", b, nb);
      chk("writes_drained", q_w_addr.size(), 0);
      chk("ars_drained", q_ar_addr.size(), 0);
      @(negedge clk);
      rvalid_i = 1'b0;
      #1;
      chk("done_one_cycle", done_o, 0);
      chk("busy_drops", busy_o, 0);
      chk("err_held", err_o, exp_err);
    end
  endtask

  initial begin
    logic [31:0] s;
    int c;
    rst = 1'b0; start_i = 1'b0; src_addr_i = '0; word_cnt_i = '0; dst_addr_i = '0;
    arready_i = 1'b0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;

    // Hand-computed burst plans that pin the model itself.
    clear_model(); build_model(32'h0000_0100, 4);
    chk("pin_a_n", q_ar_addr.size(), 1);
    chk("pin_a_addr", q_ar_addr[0], 32'h100);
    chk("pin_a_len", q_ar_len[0], 3);
    clear_model(); build_model(32'h0, 40);
    chk("pin_b_n", q_ar_addr.size(), 3);
    chk("pin_b_len0", q_ar_len[0], 15); chk("pin_b_len1", q_ar_len[1], 15); chk("pin_b_len2", q_ar_len[2], 7);
    chk("pin_b_addr1", q_ar_addr[1], 32'h40); chk("pin_b_addr2", q_ar_addr[2], 32'h80);
    clear_model(); build_model(32'h0000_0FF8, 8);
    chk("pin_c_n", q_ar_addr.size(), 2);
    chk("pin_c_len0", q_ar_len[0], 1); chk("pin_c_addr1", q_ar_addr[1], 32'h1000);
    chk("pin_c_len1", q_ar_len[1], 5);
    clear_model();

    //        src            cnt dst    stall gap resp id short long busy abort
    run_xfer(32'h0000_0100,  4, 'h010, 0,    0,  -1,  -1, -1,   -1,  -1,  0);
    run_xfer(32'h0000_0000, 40, 'h000, 0,    0,  -1,  -1, -1,   -1,  -1,  0);
    run_xfer(32'h0000_0FF8,  8, 'h3FC, 0,    0,  -1,  -1, -1,   -1,  -1,  0);
    run_xfer(32'h0000_0200,  0, 'h020, 0,    0,  -1,  -1, -1,   -1,  -1,  0);
    run_xfer(32'h0000_2000, 20, 'h005, 0,    0,  -1,  -1, -1,   -1,   3,  0);
    run_xfer(32'h0000_0FF0,  8, 'h100, 0,    0,   1,  -1,  1,   -1,  -1,  0);
    run_xfer(32'h0000_0300,  6, 'h040, 0,    0,  -1,  -1, -1,   -1,  -1,  0);
    run_xfer(32'h0000_0040, 20, 'h080, 0,    0,  -1,  -1, -1,    0,  -1,  0);
    run_xfer(32'h0000_3000, 10, 'h200, 1,   20,  -1,   5, -1,   -1,  -1,  0);
    run_xfer(32'h0000_5003, 30, 'h300, 5,   40,  -1,  -1, -1,   -1,  -1,  0);
    run_xfer(32'hFFFF_FFF0, 12, 'h3F8, 0,    0,  -1,  -1, -1,   -1,  -1,  0);
    run_xfer(32'h0000_6000, 20, 'h000, 0,    0,  -1,  -1, -1,   -1,  -1,  3);
    run_xfer(32'h0000_0100,  4, 'h010, 0,    0,  -1,  -1, -1,   -1,  -1,  0);

    for (int i = 0; i < 25; i++) begin
      s = $urandom;
      if ($urandom_range(1) == 1) s[11:2] = 10'($urandom_range(1023, 1000));
      c = $urandom_range(100, 0);
      run_xfer(s, c, int'($urandom_range(1023)), int'($urandom_range(3)),
               int'($urandom_range(50)), -1, -1, -1, -1,
               (c >= 8) ? int'($urandom_range(3, 1)) : -1, 0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
